// File: rtl/prbs23_pkg.sv
// Shared definitions for the PRBS23 (x^23 + x^18 + 1) checker: taps, FSM states and the
// word-parallel LFSR advance that must stay bit-identical to the loopback generator.
package prbs23_pkg;

    localparam int PRBS_N = 23;
    localparam int TAP_HI = PRBS_N - 1;
    localparam int TAP_FB = 18;
    localparam int TAP_LO = 0;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // One word = k single-bit shifts; the new bit enters at the top, LSB leaves first.
    function automatic logic [PRBS_N-1:0] prbs23_step(input logic [PRBS_N-1:0] x_in,
                                                      input int unsigned      k);
        logic [PRBS_N-1:0] x;
        x = x_in;
        for (int unsigned i = 0; i < k; i++) begin
            x = {x[TAP_FB] ^ x[TAP_LO], x[TAP_HI:1]};
        end
        return x;
    endfunction

endpackage

// File: rtl/prbs23_popcount.sv
// Combinational ones count of an N-bit word; used to weight err_cnt by the number of
// flipped bits when the bit-count build option is enabled.
module prbs23_popcount #(
    parameter int N    = 23,
    parameter int CNTW = $clog2(N + 1)
) (
    input  logic [N-1:0]    i_data,
    output logic [CNTW-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < N; i++) begin
            o_count = o_count + CNTW'(i_data[i]);
        end
    end

endmodule

// File: rtl/prbs23_checker.sv
// PRBS23 receive checker: hunts for lock, verifies LOCK_CNT words, then free-runs a local copy
// and counts errors. Define PRBS23_CHK_BITCNT_EN to weight err_cnt by flipped-bit popcount.
module prbs23_checker
    import prbs23_pkg::*;
#(
    parameter int N        = PRBS_N,
    parameter int K        = 23,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 8,
    parameter int CW       = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_enable,
    input  logic [N-1:0]  i_din,
    input  logic          i_clear_cnt,
    output logic          o_locked,
    output logic          o_err,
    output logic [CW-1:0] o_err_cnt,
    output logic [CW-1:0] o_word_cnt
);

    localparam int          GW       = $clog2(LOCK_CNT + 1);
    localparam int          BW       = $clog2(LOSS_CNT + 1);
    localparam int          PCW      = $clog2(N + 1);
    localparam int          AW       = ((CW > PCW) ? CW : PCW) + 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t          r_state;
    logic [N-1:0]    r_expected;
    logic [GW-1:0]   r_good_run;
    logic [BW-1:0]   r_bad_run;
    logic            r_locked;
    logic            r_err;
    logic [CW-1:0]   r_err_cnt;
    logic [CW-1:0]   r_word_cnt;

    state_t          w_state_nxt;
    logic [N-1:0]    w_expected_nxt;
    logic [GW-1:0]   w_good_run_nxt;
    logic [BW-1:0]   w_bad_run_nxt;
    logic            w_locked_nxt;
    logic            w_err_nxt;
    logic            w_word_evt;
    logic            w_err_evt;
    logic [PCW-1:0]  w_err_add;
    logic [AW-1:0]   w_err_sum;
    logic [CW-1:0]   w_err_cnt_nxt;
    logic [CW-1:0]   w_word_cnt_nxt;

    logic [N-1:0]    w_step_din;
    logic [N-1:0]    w_step_exp;
    logic            w_match;

    assign w_step_din = prbs23_step(i_din, K);
    assign w_step_exp = prbs23_step(r_expected, K);
    assign w_match    = (i_din == r_expected);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_good_run_nxt = r_good_run;
        w_bad_run_nxt  = r_bad_run;
        w_locked_nxt   = r_locked;
        w_err_nxt      = r_err;
        w_word_evt     = 1'b0;
        w_err_evt      = 1'b0;

        case (r_state)
            ST_HUNT: begin
                w_locked_nxt = 1'b0;
                w_err_nxt    = 1'b0;
                // The all-zero word is the LFSR lock-up state and can never seed a valid sequence.
                if (i_din != '0) begin
                    w_expected_nxt = w_step_din;
                    w_good_run_nxt = '0;
                    w_state_nxt    = ST_VERIFY;
                end
            end

            ST_VERIFY: begin
                if (w_match) begin
                    w_expected_nxt = w_step_din;
                    if (r_good_run == GW'(LOCK_CNT - 1)) begin
                        w_good_run_nxt = '0;
                        w_bad_run_nxt  = '0;
                        w_locked_nxt   = 1'b1;
                        w_state_nxt    = ST_LOCKED;
                    end else begin
                        w_good_run_nxt = r_good_run + GW'(1);
                    end
                end else begin
                    w_good_run_nxt = '0;
                    w_state_nxt    = ST_HUNT;
                end
            end

            ST_LOCKED: begin
                // Free-run from the local copy so a corrupted word never poisons the next compare.
                w_expected_nxt = w_step_exp;
                w_word_evt     = 1'b1;
                if (w_match) begin
                    w_err_nxt     = 1'b0;
                    w_bad_run_nxt = '0;
                end else begin
                    w_err_evt = 1'b1;
                    if (r_bad_run == BW'(LOSS_CNT - 1)) begin
                        w_bad_run_nxt = '0;
                        w_err_nxt     = 1'b0;
                        w_locked_nxt  = 1'b0;
                        w_state_nxt   = ST_HUNT;
                    end else begin
                        w_bad_run_nxt = r_bad_run + BW'(1);
                        w_err_nxt     = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt  = ST_HUNT;
                w_locked_nxt = 1'b0;
                w_err_nxt    = 1'b0;
            end
        endcase
    end

`ifdef PRBS23_CHK_BITCNT_EN
    logic [N-1:0]   w_diff;
    logic [PCW-1:0] w_popcnt;

    assign w_diff = i_din ^ r_expected;

    prbs23_popcount #(
        .N    (N),
        .CNTW (PCW)
    ) u_popcount (
        .i_data  (w_diff),
        .o_count (w_popcnt)
    );

    assign w_err_add = w_err_evt ? w_popcnt : '0;
`else
    assign w_err_add = PCW'(w_err_evt);
`endif

    // Widened add so a popcount step that crosses the maximum clamps instead of wrapping.
    assign w_err_sum      = AW'(r_err_cnt) + AW'(w_err_add);
    assign w_err_cnt_nxt  = (w_err_sum > AW'(CNT_MAX)) ? CNT_MAX : w_err_sum[CW-1:0];
    assign w_word_cnt_nxt = (w_word_evt && (r_word_cnt != CNT_MAX)) ? r_word_cnt + CW'(1)
                                                                    : r_word_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so all registers see the
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_HUNT;
            r_expected <= '0;
            r_good_run <= '0;
            r_bad_run  <= '0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
            r_word_cnt <= '0;
        end else if (i_enable) begin
            r_state    <= w_state_nxt;
            r_expected <= w_expected_nxt;
            r_good_run <= w_good_run_nxt;
            r_bad_run  <= w_bad_run_nxt;
            r_locked   <= w_locked_nxt;
            r_err      <= w_err_nxt;
            if (i_clear_cnt) begin
                r_err_cnt  <= '0;
                r_word_cnt <= '0;
            end else begin
                r_err_cnt  <= w_err_cnt_nxt;
                r_word_cnt <= w_word_cnt_nxt;
            end
        end
    end

    assign o_locked   = r_locked;
    assign o_err      = r_err;
    assign o_err_cnt  = r_err_cnt;
    assign o_word_cnt = r_word_cnt;

endmodule

// File: tb/tb_prbs23_checker.sv
// Directed bench for prbs23_checker: table of stream vectors plus hand sequences for saturation,
// clear priority, reset mid-lock and VERIFY fallback. Counters are narrowed to reach saturation.
module tb_prbs23_checker;

    localparam int N    = 23;
    localparam int CW_T = 6;
    localparam int MAXC = (1 << CW_T) - 1;
`ifdef PRBS23_CHK_BITCNT_EN
    localparam int E3   = 3;
    localparam int EALL = 23;
`else
    localparam int E3   = 1;
    localparam int EALL = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            clr;
    logic [N-1:0]    din;
    logic            locked;
    logic            err;
    logic [CW_T-1:0] err_cnt;
    logic [CW_T-1:0] word_cnt;

    prbs23_checker #(
        .N        (N),
        .K        (23),
        .LOCK_CNT (4),
        .LOSS_CNT (8),
        .CW       (CW_T)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (en),
        .i_din       (din),
        .i_clear_cnt (clr),
        .o_locked    (locked),
        .o_err       (err),
        .o_err_cnt   (err_cnt),
        .o_word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         en;
        bit [N-1:0] mask;
        bit         clr;
        bit         exp_locked;
        bit         exp_err;
        int         exp_ec;
        int         exp_wc;
    } vec_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [N-1:0] gen;
    vec_t       tbl[32];

    // Loopback generator: 23 serial shifts of x^23+x^18+1 per word.
    function automatic logic [N-1:0] gen_next(input logic [N-1:0] s);
        logic [N-1:0] v;
        logic         fb;
        v = s;
        for (int i = 0; i < 23; i++) begin
            fb = v[18] ^ v[0];
            v  = v >> 1;
            v[22] = fb;
        end
        return v;
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic vec_t mk(input bit e, input bit [N-1:0] m, input bit c,
                                input bit l, input bit er, input int ec, input int wc);
        vec_t v;
        v.en = e; v.mask = m; v.clr = c;
        v.exp_locked = l; v.exp_err = er; v.exp_ec = ec; v.exp_wc = wc;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_all(input string name, input int l, input int e, input int ec, input int wc);
        check({name, ".locked"},   int'(locked),   l);
        check({name, ".err"},      int'(err),      e);
        check({name, ".err_cnt"},  int'(err_cnt),  ec);
        check({name, ".word_cnt"}, int'(word_cnt), wc);
    endtask

    task automatic drive_raw(input logic e, input logic [N-1:0] d, input logic c);
        en = e; din = d; clr = c;
        @(posedge clk);
        #1;
        en = 1'b0; clr = 1'b0;
    endtask

    task automatic drive(input logic e, input logic [N-1:0] mask, input logic c);
        drive_raw(e, gen ^ mask, c);
        if (e) gen = gen_next(gen);
    endtask

    initial begin
        int m_ec, m_wc, run;
        bit e_exp;

        rst = 1'b1; en = 1'b0; clr = 1'b0; din = '0; gen = 23'h000001;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0);
        rst = 1'b0;

        // Lock-up word must be rejected in HUNT.
        for (int i = 0; i < 6; i++) drive_raw(1'b1, '0, 1'b0);
        check_all("zero_hunt", 0, 0, 0, 0);

        tbl[0]  = mk(1, 0,            0, 0, 0, 0,      0);
        tbl[1]  = mk(1, 0,            0, 0, 0, 0,      0);
        tbl[2]  = mk(0, 0,            0, 0, 0, 0,      0);
        tbl[3]  = mk(1, 0,            0, 0, 0, 0,      0);
        tbl[4]  = mk(1, 0,            0, 0, 0, 0,      0);
        tbl[5]  = mk(1, 0,            0, 1, 0, 0,      0);
        tbl[6]  = mk(1, 0,            0, 1, 0, 0,      1);
        tbl[7]  = mk(0, 0,            0, 1, 0, 0,      1);
        tbl[8]  = mk(1, 0,            0, 1, 0, 0,      2);
        tbl[9]  = mk(1, 23'h000001,   0, 1, 1, 1,      3);
        tbl[10] = mk(1, 0,            0, 1, 0, 1,      4);
        tbl[11] = mk(0, 0,            0, 1, 0, 1,      4);
        tbl[12] = mk(1, 23'h400005,   0, 1, 1, 1 + E3, 5);
        tbl[13] = mk(0, 0,            0, 1, 1, 1 + E3, 5);
        tbl[14] = mk(1, 0,            0, 1, 0, 1 + E3, 6);
        tbl[15] = mk(1, 0,            1, 1, 0, 0,      0);
        tbl[16] = mk(1, 23'h000001,   1, 1, 1, 0,      0);
        tbl[17] = mk(1, 0,            0, 1, 0, 0,      1);
        for (int i = 0; i < 7; i++)
            tbl[18 + i] = mk(1, 23'h000001, 0, 1, 1, i + 1, i + 2);
        tbl[25] = mk(1, 23'h000001,   0, 0, 0, 8,      9);
        tbl[26] = mk(1, 0,            0, 0, 0, 8,      9);
        tbl[27] = mk(1, 0,            0, 0, 0, 8,      9);
        tbl[28] = mk(1, 0,            0, 0, 0, 8,      9);
        tbl[29] = mk(1, 0,            0, 0, 0, 8,      9);
        tbl[30] = mk(1, 0,            0, 1, 0, 8,      9);
        tbl[31] = mk(1, 0,            0, 1, 0, 8,      10);

        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].en, tbl[i].mask, tbl[i].clr);
            check_all($sformatf("row%0d", i), int'(tbl[i].exp_locked), int'(tbl[i].exp_err),
                      tbl[i].exp_ec, tbl[i].exp_wc);
        end

        // Climb err_cnt toward the maximum with bursts of 7 errors so lock is never lost.
        m_ec = 8; m_wc = 10; run = 0;
        while (m_ec < MAXC - 3) begin
            if (run == 7) begin
                drive(1'b1, '0, 1'b0); run = 0; e_exp = 1'b0;
            end else begin
                drive(1'b1, 23'h000001, 1'b0); run++; m_ec = sat(m_ec + 1); e_exp = 1'b1;
            end
            m_wc = sat(m_wc + 1);
            check_all($sformatf("climb_ec%0d", m_ec), 1, int'(e_exp), m_ec, m_wc);
        end

        drive(1'b1, '0, 1'b0);
        m_wc = sat(m_wc + 1);
        check_all("pre_big", 1, 0, m_ec, m_wc);

        drive(1'b1, 23'h7FFFFF, 1'b0);
        m_ec = sat(m_ec + EALL); m_wc = sat(m_wc + 1);
        check_all("big_err", 1, 1, m_ec, m_wc);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 23'h000001, 1'b0);
            m_ec = sat(m_ec + 1); m_wc = sat(m_wc + 1);
            check_all($sformatf("sat%0d", i), 1, 1, m_ec, m_wc);
        end
        check("sat_hold_ec", int'(err_cnt), MAXC);
        check("sat_hold_wc", int'(word_cnt), MAXC);

        drive(1'b1, 23'h000001, 1'b1);
        check_all("clr_with_err", 1, 1, 0, 0);
        drive(1'b1, 23'h000001, 1'b0);
        check_all("err_after_clr", 1, 1, 1, 1);

        rst = 1'b1;
        drive(1'b1, '0, 1'b0);
        rst = 1'b0;
        check_all("rst_mid_lock", 0, 0, 0, 0);

        // VERIFY mismatch returns to HUNT without reseeding from the bad word.
        drive(1'b1, '0, 1'b0);
        drive(1'b1, '0, 1'b0);
        drive(1'b1, 23'h000001, 1'b0);
        check_all("verify_miss", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, '0, 1'b0);
        check_all("relock_pre", 0, 0, 0, 0);
        drive(1'b1, '0, 1'b0);
        check_all("relock", 1, 0, 0, 0);
        drive(1'b1, '0, 1'b0);
        check_all("relock_word", 1, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
